// File: rtl/uart_tx_if.sv
// Interface bundling the uart_tx handshake, tick input and serial outputs.
// The master side drives tick/tx_start/data_in; the slave (uart_tx) drives the line.
interface uart_tx_if #(
  parameter int N = 8
);
  logic         tick;
  logic         tx_start;
  logic [N-1:0] data_in;
  logic         tx;
  logic         tx_busy;
  logic         tx_done;

  modport master (
    output tick, tx_start, data_in,
    input  tx, tx_busy, tx_done
  );

  modport slave (
    input  tick, tx_start, data_in,
    output tx, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, N data bits LSB-first, optional parity, M stop bits.
// Bit timing counts pulses of a SB_TICK x baud tick; all outputs are registered, so
// the line follows the FSM state with one clock of latency.
module uart_tx #(
  parameter int N          = 8,
  parameter int M          = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int SB_TICK    = 16
) (
  input  logic    clk,
  input  logic    reset,
  uart_tx_if.slave bus
);

  localparam int ST = M * SB_TICK;
  localparam int SW = (ST > 1) ? $clog2(ST) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam logic [SW-1:0] S_BIT  = SW'(SB_TICK - 1);
  localparam logic [SW-1:0] S_STOP = SW'(ST - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  s_q, s_d;
  logic [NW-1:0]  n_q, n_d;
  logic [N-1:0]   shreg_q, shreg_d;
  logic           par_q, par_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic; the line level is taken from the current state.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = 1'b1;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A tick in the accepting cycle is deliberately not counted.
        if (bus.tx_start) begin
          shreg_d = bus.data_in;
          par_d   = (PARITY_ODD != 0) ? ~^bus.data_in : ^bus.data_in;
          s_d     = '0;
          n_d     = '0;
          state_d = START;
        end
      end
      START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
        if (bus.tick) begin
          if (s_q == S_BIT) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        tx_d   = shreg_q[0];
        busy_d = 1'b1;
        if (bus.tick) begin
          if (s_q == S_BIT) begin
            s_d     = '0;
            shreg_d = shreg_q >> 1;
            if (n_q == N_LAST) begin
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      PARITY: begin
        tx_d   = par_q;
        busy_d = 1'b1;
        if (bus.tick) begin
          if (s_q == S_BIT) begin
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        if (bus.tick) begin
          if (s_q == S_STOP) begin
            s_d     = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tx      = tx_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations share one stimulus stream and are each
// checked every cycle against a frame-level model (a tick count into a bit vector),
// plus literal frame/tick/pulse expectations for the directed cases.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] data_in = 8'h00;

  uart_tx_if #(.N(8)) if_a ();
  uart_tx_if #(.N(8)) if_b ();
  uart_tx_if #(.N(8)) if_c ();

  assign if_a.tick = tick;  assign if_a.tx_start = tx_start;  assign if_a.data_in = data_in;
  assign if_b.tick = tick;  assign if_b.tx_start = tx_start;  assign if_b.data_in = data_in;
  assign if_c.tick = tick;  assign if_c.tx_start = tx_start;  assign if_c.data_in = data_in;

  // A: 8N1, B: 8E2, C: 8O1
  uart_tx #(.N(8), .M(1), .PARITY_EN(0), .PARITY_ODD(0), .SB_TICK(16)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  uart_tx #(.N(8), .M(2), .PARITY_EN(1), .PARITY_ODD(0), .SB_TICK(16)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
  uart_tx #(.N(8), .M(1), .PARITY_EN(1), .PARITY_ODD(1), .SB_TICK(16)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

  logic [2:0] tx_w, busy_w, done_w;
  assign tx_w   = {if_c.tx, if_b.tx, if_a.tx};
  assign busy_w = {if_c.tx_busy, if_b.tx_busy, if_a.tx_busy};
  assign done_w = {if_c.tx_done, if_b.tx_done, if_a.tx_done};

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  int cfg_m  [3] = '{1, 2, 1};
  int cfg_pe [3] = '{0, 1, 1};
  int cfg_po [3] = '{0, 0, 1};

  bit          act  [3] = '{0, 0, 0};
  int          k    [3] = '{0, 0, 0};
  logic [15:0] frm  [3];
  logic        etx  [3] = '{1, 1, 1};
  logic        ebusy[3] = '{0, 0, 0};
  logic        edone[3] = '{0, 0, 0};

  function automatic logic [15:0] mk_frame(logic [7:0] d, int pe, int po);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int j = 0; j < 8; j++) f[1+j] = d[j];
    if (pe != 0) f[9] = (po != 0) ? ~^d : ^d;
    return f;
  endfunction

  // The line shows the frame bit selected by ticks already consumed, one clock late.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset) begin
        act[i] = 0; k[i] = 0; etx[i] = 1'b1; ebusy[i] = 1'b0; edone[i] = 1'b0;
      end else begin
        edone[i] = 1'b0;
        ebusy[i] = 1'b0;
        if (act[i]) begin
          etx[i]   = frm[i][k[i] / 16];
          ebusy[i] = 1'b1;
          if (tick) begin
            k[i]++;
            if (k[i] == (1 + 8 + cfg_pe[i] + cfg_m[i]) * 16) begin
              act[i] = 0; edone[i] = 1'b1; ebusy[i] = 1'b0;
            end
          end
        end else begin
          etx[i] = 1'b1;
          if (tx_start) begin
            act[i] = 1; k[i] = 0;
            frm[i] = mk_frame(data_in, cfg_pe[i], cfg_po[i]);
          end
        end
      end
    end
  end

  // ---------------- compare, capture, tick generation ----------------
  logic cap [3][0:255];
  int   cap_n   [3] = '{0, 0, 0};
  int   done_cnt[3] = '{0, 0, 0};
  int   gap_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if ({tx_w[i], busy_w[i], done_w[i]} !== {etx[i], ebusy[i], edone[i]}) begin
          fails++;
          $display("FAIL model_cmp dut%0d t=%0t tx/busy/done got %b%b%b want %b%b%b",
                   i, $time, tx_w[i], busy_w[i], done_w[i], etx[i], ebusy[i], edone[i]);
        end
        // tick here is the value seen at the preceding posedge
        if (tick && (busy_w[i] || done_w[i])) begin
          if (cap_n[i] < 256) cap[i][cap_n[i]] = tx_w[i];
          cap_n[i]++;
        end
        if (done_w[i]) done_cnt[i]++;
      end
    end
    if (gap_cnt == 0) begin
      tick = 1'b1;
      gap_cnt = $urandom_range(1, 3);
    end else begin
      tick = 1'b0;
      gap_cnt--;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  task automatic clear_cap();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      cap_n[i] = 0;
      done_cnt[i] = 0;
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    data_in  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    repeat (2) @(negedge clk);
    while (busy_w != 3'b000 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 5000) begin
      tests++; fails++;
      $display("FAIL wait_idle timeout busy=%b want 000", busy_w);
    end
    repeat (3) @(negedge clk);
  endtask

  // Frame bit j sampled mid-bit from the per-tick capture.
  function automatic int got_bits(int i, int nb);
    logic [15:0] r;
    r = '0;
    for (int j = 0; j < nb; j++) r[j] = cap[i][j*16 + 8];
    return int'(r);
  endfunction

  function automatic int trailing_ones(int i);
    int t, x;
    t = 0;
    x = cap_n[i] - 1;
    while (x >= 0 && x < 256) begin
      if (cap[i][x] !== 1'b1) break;
      t++;
      x--;
    end
    return t;
  endfunction

  // ---------------- directed + random stimulus ----------------
  initial begin
    int c, gap;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("reset_out", {tx_w[i], busy_w[i], done_w[i]}, 3'b100);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // 0x15 on all three configurations
    clear_cap(); send(8'h15); wait_idle();
    chk("a_0x15_bits", got_bits(0, 10), 'h22A);
    chk("b_0x15_bits", got_bits(1, 12), 'hE2A);
    chk("c_0x15_bits", got_bits(2, 11), 'h42A);
    chk("a_frame_ticks", cap_n[0], 160);
    chk("b_frame_ticks", cap_n[1], 192);
    chk("c_frame_ticks", cap_n[2], 176);
    for (int i = 0; i < 3; i++) chk("done_once", done_cnt[i], 1);

    // parity of 0x07: even -> 1, odd -> 0
    clear_cap(); send(8'h07); wait_idle();
    chk("a_0x07_bits", got_bits(0, 10), 'h20E);
    chk("b_0x07_even_par", got_bits(1, 12), 'hE0E);
    chk("c_0x07_odd_par", got_bits(2, 11), 'h40E);

    // two stop bits: 32 ticks of stop level after a 0 parity bit
    clear_cap(); send(8'hFF); wait_idle();
    chk("b_0xFF_bits", got_bits(1, 12), 'hDFE);
    chk("b_stop_ticks", trailing_ones(1), 32);
    chk("c_0xFF_bits", got_bits(2, 11), 'h7FE);

    // start during a frame is ignored
    clear_cap(); send(8'h15);
    repeat (100) @(negedge clk);
    send(8'hAA); wait_idle();
    chk("ignore_bits", got_bits(0, 10), 'h22A);
    chk("ignore_done", done_cnt[0], 1);

    // held start: back-to-back with one idle clock, second word changed after acceptance
    @(negedge clk);
    data_in = 8'h15; tx_start = 1'b1;
    @(negedge clk);
    data_in = 8'h11;
    c = 0;
    while (!done_w[0] && c < 3000) begin @(negedge clk); c++; end
    gap = 0;
    c = 0;
    do begin @(negedge clk); c++; if (!busy_w[0]) gap++; end while (!busy_w[0] && c < 10);
    chk("b2b_idle_clks", gap, 1);
    tx_start = 1'b0;
    wait_idle();

    // reset during data bit 3 of 0x55
    clear_cap(); send(8'h55);
    c = 0;
    while (cap_n[0] < 72 && c < 3000) begin @(negedge clk); c++; end
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_out", {tx_w[0], busy_w[0], done_w[0]}, 3'b100);
    chk("midreset_busy_all", busy_w, 3'b000);
    chk("midreset_no_done", done_cnt[0], 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    clear_cap(); send(8'h0F); wait_idle();
    chk("after_reset_bits", got_bits(0, 10), 'h21E);
    chk("after_reset_done", done_cnt[0], 1);

    // random traffic with occasional one-cycle resets
    for (int r = 0; r < 9000; r++) begin
      @(negedge clk);
      tx_start = ($urandom_range(0, 39) == 0);
      data_in  = 8'($urandom);
      reset    = ($urandom_range(0, 2999) != 0);
    end
    tx_start = 1'b0;
    reset = 1'b1;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(4_000_000);
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
